// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths, FSM state and access-class types for the 4Kx32 SRAM arbiter.
package sram_arb_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {IDLE, RMW} state_t;
    typedef enum logic [1:0] {ACC_R, ACC_FW, ACC_PW, ACC_NOP} acc_t;

    // Without RMW support every write is treated as a full-word write.
    function automatic acc_t acc_class(input logic we, input logic [BE_W-1:0] be, input logic rmw);
        return !we ? ACC_R : (!rmw || &be) ? ACC_FW : (be == '0) ? ACC_NOP : ACC_PW;
    endfunction
endpackage

// File: rtl/sram_arb_be_merge.sv
// sram_arb_be_merge: per-byte merge of old SRAM data with new write data under byte enables.
module sram_arb_be_merge
    import sram_arb_pkg::*;
(
    input  logic [DATA_W-1:0] i_rd,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_wd
);
    for (genvar i = 0; i < BE_W; i++) begin : g_byte
        assign o_wd[8*i +: 8] = i_be[i] ? i_wdata[8*i +: 8] : i_rd[8*i +: 8];
    end
endmodule

// File: rtl/sram_4kx32_arb.sv
// sram_4kx32_arb: two-requester arbiter/sequencer for a 4Kx32 1R1W single-clock SRAM.
// Define SRAM_ARB_RMW_EN to turn partial byte-enable writes into read-modify-write sequences.
module sram_4kx32_arb
    import sram_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_a,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [BE_W-1:0]   i_be_a,
    input  logic [DATA_W-1:0] i_wdata_a,
    output logic              o_gnt_a,
    output logic              o_rvalid_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic              i_req_b,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [BE_W-1:0]   i_be_b,
    input  logic [DATA_W-1:0] i_wdata_b,
    output logic              o_gnt_b,
    output logic              o_rvalid_b,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [ADDR_W-1:0] o_sram_raddr,
    output logic [ADDR_W-1:0] o_sram_waddr,
    output logic [DATA_W-1:0] o_sram_wd,
    output logic              o_sram_wen,
    input  logic [DATA_W-1:0] i_sram_rd
);
`ifdef SRAM_ARB_RMW_EN
    localparam logic RMW_EN = 1'b1;
`else
    localparam logic RMW_EN = 1'b0;
`endif
    acc_t              w_cls_a, w_cls_b;
    logic              w_ra, w_fa, w_pa, w_rb, w_fb, w_pb;
    logic              w_pair, w_same, w_idle, w_in_rmw;
    logic              w_gnt_a, w_gnt_b, w_rd_a, w_rd_b, w_fw_a, w_fw_b;
    logic              r_ptr, r_rvalid_a, r_rvalid_b;
    logic [ADDR_W-1:0] r_raddr, w_raddr, w_rmw_addr;
    logic [DATA_W-1:0] w_rmw_wd;

    assign w_cls_a = acc_class(i_we_a, i_be_a, RMW_EN);
    assign w_cls_b = acc_class(i_we_b, i_be_b, RMW_EN);
    assign w_ra    = w_cls_a == ACC_R;
    assign w_fa    = w_cls_a == ACC_FW;
    assign w_pa    = w_cls_a == ACC_PW;
    assign w_rb    = w_cls_b == ACC_R;
    assign w_fb    = w_cls_b == ACC_FW;
    assign w_pb    = w_cls_b == ACC_PW;
    assign w_same  = i_addr_a == i_addr_b;
    assign w_pair  = (w_ra && w_fb) || (w_fa && w_rb);
    assign w_idle  = !i_rst && !w_in_rmw;

    // A read/full-write pair on one address lets the write through first so the read sees new data.
    always_comb begin
        w_gnt_a      = w_idle && i_req_a && (!i_req_b || (w_pair ? (!w_same || w_fa) : !r_ptr));
        w_gnt_b      = w_idle && i_req_b && (!i_req_a || (w_pair ? (!w_same || w_fb) : r_ptr));
        w_rd_a       = w_gnt_a && (w_ra || w_pa);
        w_rd_b       = w_gnt_b && (w_rb || w_pb);
        w_fw_a       = w_gnt_a && w_fa;
        w_fw_b       = w_gnt_b && w_fb;
        w_raddr      = w_rd_a ? i_addr_a : w_rd_b ? i_addr_b : r_raddr;
        o_sram_wen   = !i_rst && (w_in_rmw || w_fw_a || w_fw_b);
        o_sram_waddr = w_in_rmw ? w_rmw_addr : w_fw_b ? i_addr_b : i_addr_a;
        o_sram_wd    = w_in_rmw ? w_rmw_wd : w_fw_b ? i_wdata_b : i_wdata_a;
    end

    assign o_gnt_a      = w_gnt_a;
    assign o_gnt_b      = w_gnt_b;
    assign o_sram_raddr = w_raddr;
    assign o_rvalid_a   = r_rvalid_a;
    assign o_rvalid_b   = r_rvalid_b;
    assign o_rdata_a    = r_rvalid_a ? i_sram_rd : '0;
    assign o_rdata_b    = r_rvalid_b ? i_sram_rd : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_raddr    <= '0;
        end else begin
            if (i_req_a && i_req_b && (w_gnt_a ^ w_gnt_b))
                r_ptr <= w_gnt_a;
            r_rvalid_a <= w_gnt_a && w_ra;
            r_rvalid_b <= w_gnt_b && w_rb;
            r_raddr    <= w_raddr;
        end
    end

`ifdef SRAM_ARB_RMW_EN
    state_t            r_state, w_next;
    logic              w_pw_a, w_pw_b, w_pw_go;
    logic [ADDR_W-1:0] r_pw_addr;
    logic [BE_W-1:0]   r_pw_be;
    logic [DATA_W-1:0] r_pw_wdata;

    assign w_pw_a  = w_gnt_a && w_pa;
    assign w_pw_b  = w_gnt_b && w_pb;
    assign w_pw_go = w_pw_a || w_pw_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb w_next = (r_state == IDLE && w_pw_go) ? RMW : IDLE;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pw_addr  <= '0;
            r_pw_be    <= '0;
            r_pw_wdata <= '0;
        end else if (w_pw_go) begin
            r_pw_addr  <= w_pw_b ? i_addr_b : i_addr_a;
            r_pw_be    <= w_pw_b ? i_be_b : i_be_a;
            r_pw_wdata <= w_pw_b ? i_wdata_b : i_wdata_a;
        end
    end

    sram_arb_be_merge u_merge (
        .i_rd    (i_sram_rd),
        .i_wdata (r_pw_wdata),
        .i_be    (r_pw_be),
        .o_wd    (w_rmw_wd)
    );

    assign w_rmw_addr = r_pw_addr;
    assign w_in_rmw   = r_state == RMW;
`else
    assign w_rmw_addr = '0;
    assign w_rmw_wd   = '0;
    assign w_in_rmw   = 1'b0;
`endif
endmodule

// File: doc/sram_4kx32_arb.md
# sram_4kx32_arb

Two-requester arbiter and sequencer for the 4K×32 two-port SRAM (one read port, one write port, single clock, 1-cycle read latency). It sits between the core data port (A) and the DMA/debug port (B) and the memory macro. It round-robins conflicting accesses and grants a read and a write in the same cycle when they don't collide. Byte-enable writes are turned into read-modify-write (RMW) sequences, because the macro has only a word write enable.

## Interface
- ADDR_W, 12, word address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits wide

Ports (x ∈ {a, b}):
- CLK  in  1  the only clock; every flop samples on its rising edge
- RST  in  1  reset, asynchronous and active-high
- req_x  in  1  access request; held stable until gnt_x
- we_x  in  1  1 = write, 0 = read
- addr_x  in  ADDR_W  word address
- be_x  in  DATA_W/8  byte enables (writes only)
- wdata_x  in  DATA_W  write data
- gnt_x  out  1  combinational accept, same cycle as req_x
- rvalid_x  out  1  read data valid, one cycle after the read's gnt_x
- rdata_x  out  DATA_W  sram_rd when rvalid_x=1, else 0
- sram_raddr  out  ADDR_W  to RADDR
- sram_waddr  out  ADDR_W  to WADDR
- sram_wd  out  DATA_W  to WD
- sram_wen  out  1  to WEN
- sram_rd  in  DATA_W  from RD; valid the cycle after RADDR is sampled

## Operation
States: IDLE, RMW.

Access classes:
- Read: R
- Full write (be all ones): FW
- Partial write (be neither zero nor all ones): PW
- be=0 write: granted; no SRAM write

Grants in IDLE:
- Single requester: granted.
- R vs FW, different addresses: both granted in the same cycle.
- R vs FW, same address: FW granted; R waits and is granted next cycle, so it returns the new data.
- Any other pair (R/R, W/W, R/PW): round-robin winner only.

Round-robin:
- A 1-bit pointer favours the requester not granted last.
- It updates only when both requested and exactly one was granted.

Port behaviour:
- R: sram_raddr=addr; rvalid_x=1 in the next cycle.
- FW: sram_wen=1; waddr and wd taken directly from the requester.
- PW: the grant cycle drives sram_raddr=addr and latches addr, be, wdata and owner; go to RMW.
- RMW state (one cycle): sram_wen=1, sram_waddr=latched addr, sram_wd = per-byte merge (be ? wdata : sram_rd).
  - No grants are issued in RMW.
  - The next state is always IDLE.

Idle outputs:
- When no read is granted, sram_raddr holds its last value.
- When no write is issued, sram_wen=0.

## Timing
- Reset values: state=IDLE, pointer=A, rvalid_a/b=0, rdata_a/b=0, gnt_a/b=0, sram_wen=0.
- gnt_x is forced to 0 while RST is high.
- Latencies:
  - Read: 1 cycle, gnt → rvalid.
  - FW: 0 cycles; the write is committed at the gnt edge.
  - PW: 2 cycles; the port is busy for one extra cycle.
- Throughput:
  - Back-to-back reads from one port: one per cycle, rvalid continuous.
  - R and FW combined: two accesses per cycle.
- Reset during RMW: the state returns to IDLE, the merged write is dropped (sram_wen=0), and memory is unchanged.
- Reset in the cycle after a read grant: rvalid is forced to 0.
- Address wrap: none; the address is exactly ADDR_W bits.
- Read/write on the same address in the same cycle is never issued.

## Configuration
- SRAM_ARB_RMW_EN defined:
  - PW is handled through the RMW state.
  - A be=0 write is a no-op.
- SRAM_ARB_RMW_EN undefined:
  - be is ignored and every write is FW.
  - The RMW state, the latches and the merge logic are removed.

## Structure
- Package sram_arb_pkg holds:
  - ADDR_W and DATA_W defaults, and the BE_W derivation
  - state enum {IDLE, RMW}
  - access-class enum {ACC_R, ACC_FW, ACC_PW, ACC_NOP}
- One sub-module, sram_arb_be_merge: combinational per-byte merge of sram_rd and wdata under be. Instantiated only with SRAM_ARB_RMW_EN.

## Test plan
1. A FW 0x010 ← 0xDEADBEEF, then A R 0x010 → gnt_a in the same cycle; next cycle rvalid_a=1, rdata_a=0xDEADBEEF.
2. B PW 0x010, be=4'b0011, wdata=0x00001234 → one busy cycle with gnt_a=gnt_b=0 during RMW; a following R 0x010 returns 0xDEAD1234.
3. A and B both hold R for 4 cycles after reset → grants A, B, A, B; rvalid alternates.
4. A R 0x020 with B FW 0x021 → both gnt in the same cycle. A R 0x020 with B FW 0x020 ← 0x5 → gnt_b first, gnt_a next cycle, rdata_a=0x5.
5. RST asserted in the RMW cycle of a PW to 0x030 (old value 0x11223344) → sram_wen=0 and all outputs at reset values; a later read returns 0x11223344.
6. Built without SRAM_ARB_RMW_EN: A write be=4'b0001 wdata=0xAABBCCDD to 0x040 → single-cycle FW; a read returns 0xAABBCCDD.
